tx_arbiter: RTL

//  Shares one transmission_module among NUM_REQ requesters. Requesters are

---
 rtl/tx_arbiter_if.sv | 34 +++
 rtl/tx_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/tx_arbiter_if.sv
// Bundle between the requesters/transmission_module side and tx_arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface tx_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int PRSCL_WIDTH = 8
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                 req_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_i;
  logic [PRSCL_WIDTH-1:0]             prescl_i;
  logic [NUM_REQ-1:0]                 ack_o;
  logic [NUM_REQ-1:0]                 done_o;
  logic                               err_o;
  logic [IDX_W-1:0]                   grant_id_o;
  logic                               idle_o;
  logic [DATA_WIDTH-1:0]              tx_data_o;
  logic [PRSCL_WIDTH-1:0]             tx_prescl_o;
  logic                               tx_start_o;
  logic                               tx_busy_i;

  modport slave (
    input  req_i, data_i, prescl_i, tx_busy_i,
    output ack_o, done_o, err_o, grant_id_o, idle_o,
           tx_data_o, tx_prescl_o, tx_start_o
  );

  modport master (
    output req_i, data_i, prescl_i, tx_busy_i,
    input  ack_o, done_o, err_o, grant_id_o, idle_o,
           tx_data_o, tx_prescl_o, tx_start_o
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin sharing of one transmission_module among NUM_REQ requesters:
// arbitrate, latch byte/prescaler, strobe start, track busy, then idle gap.
module tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int PRSCL_WIDTH = 8,
  parameter int BUSY_WAIT   = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  tx_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(BUSY_WAIT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       ptr, winner, cand;
  logic [TMR_W-1:0]       tmr;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   any_req, found, tmr_exp, gap_exp;
  logic [NUM_REQ-1:0]     ack_q, done_q;
  logic                   err_q, start_q;
  logic [IDX_W-1:0]       grant_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [PRSCL_WIDTH-1:0] prscl_q;

  assign any_req = |bus.req_i;
  assign tmr_exp = (tmr >= TMR_W'(BUSY_WAIT - 1));
  assign gap_exp = (gap_cnt >= GAP_W'(GAP_CYCLES - 1));

  // First requester after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && bus.req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req) state_nxt = LOAD;
      LOAD:      state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy_i) state_nxt = WAIT_DONE;
                 else if (tmr_exp)  state_nxt = GAP;
      WAIT_DONE: if (!bus.tx_busy_i) state_nxt = GAP;
      GAP:       if (gap_exp) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr     <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      prscl_q <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      tmr     <= '0;
      gap_cnt <= '0;
    end else begin
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          ptr     <= winner;
          grant_q <= winner;
        end
        LOAD: begin
          data_q     <= bus.data_i[ptr];
          prscl_q    <= bus.prescl_i;
          ack_q[ptr] <= 1'b1;
        end
        START: begin
          start_q <= 1'b1;
          tmr     <= '0;
        end
        WAIT_BUSY: if (!bus.tx_busy_i) begin
          if (tmr_exp) begin
            err_q   <= 1'b1;
            gap_cnt <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        WAIT_DONE: if (!bus.tx_busy_i) begin
          done_q[ptr] <= 1'b1;
          gap_cnt     <= '0;
        end
        GAP: if (!gap_exp) gap_cnt <= gap_cnt + GAP_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.tx_start_o  = start_q;
  assign bus.grant_id_o  = grant_q;
  assign bus.tx_data_o   = data_q;
  assign bus.tx_prescl_o = prscl_q;
  assign bus.idle_o      = (state == IDLE);
endmodule
